// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encodings and widths for the PC sequencer
package pc_seq_pkg;
   localparam int STATE_W       = 3;
   localparam int DEFAULT_WIDTH = 16;

   localparam logic [STATE_W-1:0] S_RST    = 3'd0;
   localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
   localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
   localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
   localparam logic [STATE_W-1:0] S_UPDATE = 3'd4;
   localparam logic [STATE_W-1:0] S_HALT   = 3'd5;
endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - EXEC-stage next-PC priority mux and adders
// Optional call/return selection under PCSEQ_LINK_EN.
module pc_target_sel
   import pc_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] i_pc,
   input  logic             i_jump_req,
   input  logic [WIDTH-1:0] i_jump_addr,
   input  logic             i_branch_req,
   input  logic             i_branch_cond,
   input  logic [WIDTH-1:0] i_branch_off,
`ifdef PCSEQ_LINK_EN
   input  logic             i_call_req,
   input  logic             i_ret_req,
   input  logic [WIDTH-1:0] i_link,
`endif
   output logic [WIDTH-1:0] o_seq_pc,
   output logic [WIDTH-1:0] o_target
);
   logic [WIDTH-1:0] w_branch_pc;

   // Both adders wrap modulo 2^WIDTH; the offset is two's complement.
   assign o_seq_pc    = i_pc + WIDTH'(STEP);
   assign w_branch_pc = i_pc + i_branch_off;

   always_comb begin
      o_target = o_seq_pc;
      if (i_jump_req) begin
         o_target = i_jump_addr;
`ifdef PCSEQ_LINK_EN
      end else if (i_call_req) begin
         o_target = i_jump_addr;
      end else if (i_ret_req) begin
         o_target = i_link;
`endif
      end else if (i_branch_req && i_branch_cond) begin
         o_target = w_branch_pc;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - FETCH/DECODE/EXEC/UPDATE sequencer driving the program counter
// Optional one-entry link register under PCSEQ_LINK_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH        = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               STEP         = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   pc_in,
   input  logic               stall,
   input  logic               branch_req,
   input  logic               branch_cond,
   input  logic [WIDTH-1:0]   branch_off,
   input  logic               jump_req,
   input  logic [WIDTH-1:0]   jump_addr,
   input  logic               halt_req,
   input  logic               resume,
`ifdef PCSEQ_LINK_EN
   input  logic               call_req,
   input  logic               ret_req,
   output logic [WIDTH-1:0]   link_out,
`endif
   output logic               pWrite,
   output logic [WIDTH-1:0]   pc_next,
   output logic               ir_load,
   output logic [STATE_W-1:0] state,
   output logic               halted
);
   logic [STATE_W-1:0] r_state;
   logic [WIDTH-1:0]   r_target;
   logic [WIDTH-1:0]   w_exec_target;
   logic [WIDTH-1:0]   w_seq_pc;

`ifdef PCSEQ_LINK_EN
   logic [WIDTH-1:0]   r_link;
   assign link_out = r_link;
`endif

   pc_target_sel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_target_sel (
      .i_pc          (pc_in),
      .i_jump_req    (jump_req),
      .i_jump_addr   (jump_addr),
      .i_branch_req  (branch_req),
      .i_branch_cond (branch_cond),
      .i_branch_off  (branch_off),
`ifdef PCSEQ_LINK_EN
      .i_call_req    (call_req),
      .i_ret_req     (ret_req),
      .i_link        (r_link),
`endif
      .o_seq_pc      (w_seq_pc),
      .o_target      (w_exec_target)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_RST;
         r_target <= RESET_VECTOR;
`ifdef PCSEQ_LINK_EN
         r_link   <= RESET_VECTOR;
`endif
      end else begin
         case (r_state)
            S_RST:    r_state <= S_FETCH;
            S_FETCH:  if (!stall) r_state <= S_DECODE;
            S_DECODE: if (!stall) r_state <= S_EXEC;
            S_EXEC: begin
               if (!stall) begin
                  if (halt_req) begin
                     r_state <= S_HALT;
                  end else begin
                     r_target <= w_exec_target;
                     r_state  <= S_UPDATE;
`ifdef PCSEQ_LINK_EN
                     if (call_req && !jump_req) r_link <= w_seq_pc;
`endif
                  end
               end
            end
            S_UPDATE: if (!stall) r_state <= S_FETCH;
            // Resuming refetches the PC that was current when the halt hit.
            S_HALT:   if (resume) r_state <= S_FETCH;
            default:  r_state <= S_RST;
         endcase
      end
   end

`ifndef PCSEQ_LINK_EN
   logic w_unused_seq;
   assign w_unused_seq = ^w_seq_pc;
`endif

   assign state   = r_state;
   assign pWrite  = (r_state == S_RST) || (r_state == S_UPDATE);
   assign pc_next = (r_state == S_RST) ? RESET_VECTOR : r_target;
   assign ir_load = (r_state == S_FETCH);
   assign halted  = (r_state == S_HALT);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a PC model
module tb_pc_sequencer;
   localparam logic [15:0] RV = 16'h0000;

   logic        clk = 1'b0;
   logic        rst, stall, branch_req, branch_cond, jump_req, halt_req, resume;
   logic [15:0] pc_in, branch_off, jump_addr, pc_next;
   logic        pWrite, ir_load, halted;
   logic [2:0]  state;
`ifdef PCSEQ_LINK_EN
   logic        call_req = 1'b0;
   logic        ret_req  = 1'b0;
   logic [15:0] link_out;
`endif

   logic [15:0] r_pc = 16'h5A5A;
   logic [15:0] m_pc;
   int          checks = 0;
   int          errors = 0;

   pc_sequencer #(.WIDTH(16), .RESET_VECTOR(RV), .STEP(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .stall       (stall),
      .branch_req  (branch_req),
      .branch_cond (branch_cond),
      .branch_off  (branch_off),
      .jump_req    (jump_req),
      .jump_addr   (jump_addr),
      .halt_req    (halt_req),
      .resume      (resume),
`ifdef PCSEQ_LINK_EN
      .call_req    (call_req),
      .ret_req     (ret_req),
      .link_out    (link_out),
`endif
      .pWrite      (pWrite),
      .pc_next     (pc_next),
      .ir_load     (ir_load),
      .state       (state),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // Program counter model: loads pc_next whenever write enable is high.
   always @(posedge clk) if (pWrite) r_pc <= pc_next;
   assign pc_in = r_pc;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      branch_req = 0; branch_cond = 0; jump_req = 0; halt_req = 0;
      branch_off = 16'h0; jump_addr = 16'h0;
   endtask

   task automatic junk();
      branch_req  = 1'($urandom);
      branch_cond = 1'($urandom);
      jump_req    = 1'($urandom);
      halt_req    = 1'($urandom);
      branch_off  = 16'($urandom);
      jump_addr   = 16'($urandom);
   endtask

   // One instruction starting from a FETCH sample point; ends at the next FETCH.
   task automatic instr(input logic h, input logic j, input logic [15:0] ja, input logic b,
                        input logic c, input logic [15:0] off, input int ds, input int us);
      logic [15:0] exp;
      check("fetch_state", state, 3'd1);
      check("fetch_ir_load", ir_load, 1'b1);
      check("fetch_pwrite", pWrite, 1'b0);
      check("fetch_pc", pc_in, m_pc);
      junk();
      stall = 0;
      @(negedge clk);
      check("decode_state", state, 3'd2);
      check("decode_ir_load", ir_load, 1'b0);
      if (ds > 0) begin
         stall = 1;
         for (int i = 0; i < ds; i++) begin
            @(negedge clk);
            check("stall_state", state, 3'd2);
            check("stall_pwrite", pWrite, 1'b0);
         end
         stall = 0;
      end
      clr();
      @(negedge clk);
      check("exec_state", state, 3'd3);
      check("exec_pwrite", pWrite, 1'b0);
      halt_req = h; jump_req = j; jump_addr = ja;
      branch_req = b; branch_cond = c; branch_off = off;
      if (j)           exp = ja;
      else if (b && c) exp = m_pc + off;
      else             exp = m_pc + 16'd1;
      @(negedge clk);
      clr();
      if (h) begin
         check("halt_state", state, 3'd5);
         for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom);
            @(negedge clk);
            check("halt_hold", state, 3'd5);
            check("halt_halted", halted, 1'b1);
            check("halt_pwrite", pWrite, 1'b0);
         end
         stall = 0;
         resume = 1;
         @(negedge clk);
         resume = 0;
      end else begin
         check("update_state", state, 3'd4);
         check("update_pwrite", pWrite, 1'b1);
         check("update_pc_next", pc_next, exp);
         check("update_halted", halted, 1'b0);
         if (us > 0) begin
            stall = 1;
            for (int i = 0; i < us; i++) begin
               @(negedge clk);
               check("ustall_state", state, 3'd4);
               check("ustall_pwrite", pWrite, 1'b1);
               check("ustall_pc_next", pc_next, exp);
            end
            stall = 0;
         end
         @(negedge clk);
         m_pc = exp;
      end
   endtask

   initial begin
      rst = 1; stall = 1; resume = 0;
      clr();
      repeat (2) @(negedge clk);
      check("rst_state", state, 3'd0);
      check("rst_pwrite", pWrite, 1'b1);
      check("rst_pc_next", pc_next, RV);
      check("rst_ir_load", ir_load, 1'b0);
      check("rst_halted", halted, 1'b0);
      rst = 0;
      @(negedge clk);
      m_pc = RV;

      // Sequential run: 0001, 0002, 0003
      for (int i = 0; i < 3; i++) instr(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
      // Jump beats taken branch
      instr(0, 1, 16'h0005, 0, 0, 16'h0, 0, 0);
      instr(0, 1, 16'h1234, 1, 1, 16'h0040, 0, 0);
      // Negative offset taken, then not taken
      instr(0, 1, 16'h0010, 0, 0, 16'h0, 0, 0);
      instr(0, 0, 16'h0, 1, 1, 16'hFFF8, 0, 0);
      check("branch_neg_pc", pc_in, 16'h0008);
      instr(0, 1, 16'h0010, 0, 0, 16'h0, 0, 0);
      instr(0, 0, 16'h0, 1, 0, 16'hFFF8, 0, 0);
      check("branch_nt_pc", pc_in, 16'h0011);
      // Wrap at top of address space
      instr(0, 1, 16'hFFFF, 0, 0, 16'h0, 0, 0);
      instr(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
      check("wrap_pc", pc_in, 16'h0000);
      // Stall in DECODE then in UPDATE
      instr(0, 0, 16'h0, 0, 0, 16'h0, 3, 0);
      instr(0, 0, 16'h0, 1, 1, 16'h0020, 0, 2);
      // Halt has top priority, PC frozen across resume
      instr(1, 1, 16'hBEEF, 1, 1, 16'h0004, 0, 0);
      instr(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         instr(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0), 16'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // Reset during UPDATE with target 00AA
      check("pre_rst_state", state, 3'd1);
      @(negedge clk);
      @(negedge clk);
      jump_req = 1; jump_addr = 16'h00AA;
      @(negedge clk);
      clr();
      check("mid_update_pc_next", pc_next, 16'h00AA);
      rst = 1;
      @(negedge clk);
      check("mid_rst_state", state, 3'd0);
      check("mid_rst_pc_next", pc_next, RV);
      check("mid_rst_pwrite", pWrite, 1'b1);
      rst = 0;
      @(negedge clk);
      check("post_rst_state", state, 3'd1);
      check("post_rst_pc", pc_in, RV);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit program counter (programcounter).
- Steps each instruction through FETCH/DECODE/EXEC/UPDATE.
- Selects the next PC: sequential, taken branch, absolute jump or reset vector.
- Drives the counter's write enable and data input.
- Supports external stall, halt and resume.

Parameters:
WIDTH, 16, PC width in bits
RESET_VECTOR, 16'h0000, PC value loaded after reset
STEP, 1, sequential PC increment

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
pc_in  input  WIDTH  current PC (counter out)
stall  input  1  freeze sequencer in current state
branch_req  input  1  conditional branch instruction, sampled in EXEC
branch_cond  input  1  branch condition, sampled in EXEC
branch_off  input  WIDTH  signed two's-complement branch offset
jump_req  input  1  absolute jump, sampled in EXEC
jump_addr  input  WIDTH  jump target
halt_req  input  1  halt request, sampled in EXEC
resume  input  1  leave HALT
pWrite  output  1  PC write enable to counter
pc_next  output  WIDTH  PC data to counter (temp_in)
ir_load  output  1  instruction register load strobe
state  output  3  current FSM state encoding
halted  output  1  high while in HALT

Behaviour:
- Reset: rst high at an edge forces state=S_RST and target_q=RESET_VECTOR. This overrides stall, halt and every request, in any state, including mid-instruction.
- States (3-bit): S_RST=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_UPDATE=4, S_HALT=5. Codes 6 and 7 go to S_RST.
- Outputs are Moore-decoded from the state register and target_q:
  - pWrite=1 only in S_RST and S_UPDATE.
  - pc_next = RESET_VECTOR in S_RST, otherwise target_q.
  - ir_load=1 only in S_FETCH.
  - halted=1 only in S_HALT.
  - Values during and immediately after reset: pWrite=1, pc_next=RESET_VECTOR, ir_load=0, halted=0, state=0.
- Transitions:
  - S_RST goes to S_FETCH unconditionally; stall is ignored.
  - S_FETCH to S_DECODE to S_EXEC to S_UPDATE to S_FETCH.
  - stall=1 holds S_FETCH, S_DECODE, S_EXEC and S_UPDATE.
  - In a stalled S_UPDATE, pWrite stays high with the same pc_next; repeated identical writes are harmless.
- EXEC decision on a non-stalled S_EXEC edge, fixed priority:
  1. halt_req: next state S_HALT, target_q unchanged.
  2. jump_req: target_q = jump_addr.
  3. branch_req & branch_cond: target_q = pc_in + branch_off.
  4. Otherwise: target_q = pc_in + STEP.
  - Cases 2 to 4 go to S_UPDATE.
  - branch_req with branch_cond=0 is sequential.
- Arithmetic: all additions are modulo 2^WIDTH. 16'hFFFF + 1 gives 16'h0000. Negative offsets wrap, e.g. 16'h0002 + 16'hFFFC gives 16'hFFFE.
- S_HALT: pWrite=0 and the PC is frozen. resume=1 moves to S_FETCH, refetching the same PC. Stall is ignored in S_HALT.
- Latency: sequential instruction takes 4 cycles. The PC update is visible on pc_in the cycle after S_UPDATE, which is the following S_FETCH.

Optional Feature:
PCSEQ_LINK_EN
- Defined:
  - Adds inputs call_req and ret_req, and output link_out[WIDTH], a one-entry link register with reset value RESET_VECTOR.
  - EXEC priority becomes halt > jump > call > ret > branch > sequential.
  - call: target_q = jump_addr and link = pc_in + STEP.
  - ret: target_q = link.
  - call and ret together: call wins.
- Undefined: these ports and the register are absent, and behaviour is exactly as above.

Decomposition:
- Package pc_seq_pkg holds:
  - state encodings S_RST..S_HALT
  - STATE_W=3
  - default WIDTH
- Sub-module pc_target_sel: combinational priority mux and adders producing the EXEC target. The FSM, target_q and link register stay in pc_sequencer.

Test Plan:
- Reset then run, all requests 0: pWrite=1 with pc_next=0000 in S_RST; then pc_next=0001, 0002, 0003 pulsed every 4 cycles; ir_load once per instruction.
- Jump: pc_in=0005, jump_req=1 and branch_req=1 with branch_cond=1 in EXEC, jump_addr=1234 -> pc_next=1234 in the UPDATE cycle (jump beats branch).
- Branches: pc_in=0010 with offset FFF8 taken -> 0008; same with branch_cond=0 -> 0011. Wrap: pc_in=FFFF sequential -> 0000.
- Stall: stall=1 for 3 cycles during S_DECODE -> state stays 2, no pWrite; instruction completes 3 cycles late with the correct target.
- Halt and resume: halt_req in EXEC -> S_HALT, halted=1, pWrite=0 for 10 cycles; resume=1 -> S_FETCH with pc_in unchanged.
- Reset mid-instruction: rst=1 during S_UPDATE with target 00AA -> next state S_RST, pc_next=RESET_VECTOR; no write of 00AA after reset.
